// File: rtl/router_port_rx_if.sv
// -----------------------------------------------------------------------------
// router_port_rx_if
// Purpose : Groups the serial input and byte-stream output of router_port_rx.
//           Optional statistics signals exist only when RX_STATS_EN is defined.
// Signals :
//   dout, valido_n, frameo_n   serial side, driven by the router output port
//   byte_data/sop/eop/valid    head-of-FIFO byte stream, driven by the receiver
//   byte_ready                 consumer acceptance
//   overflow, frame_err        sticky status flags
//   pkt_cnt, drop_cnt          (RX_STATS_EN) eop bytes pushed / bytes dropped
// Modports:
//   master - the environment (router and consumer side)
//   slave  - router_port_rx itself
// -----------------------------------------------------------------------------
interface router_port_rx_if;
    logic       dout;
    logic       valido_n;
    logic       frameo_n;
    logic [7:0] byte_data;
    logic       byte_sop;
    logic       byte_eop;
    logic       byte_valid;
    logic       byte_ready;
    logic       overflow;
    logic       frame_err;
`ifdef RX_STATS_EN
    logic [15:0] pkt_cnt;
    logic [15:0] drop_cnt;

    modport master (
        output dout, valido_n, frameo_n, byte_ready,
        input  byte_data, byte_sop, byte_eop, byte_valid, overflow, frame_err,
        input  pkt_cnt, drop_cnt
    );
    modport slave (
        input  dout, valido_n, frameo_n, byte_ready,
        output byte_data, byte_sop, byte_eop, byte_valid, overflow, frame_err,
        output pkt_cnt, drop_cnt
    );
`else
    modport master (
        output dout, valido_n, frameo_n, byte_ready,
        input  byte_data, byte_sop, byte_eop, byte_valid, overflow, frame_err
    );
    modport slave (
        input  dout, valido_n, frameo_n, byte_ready,
        output byte_data, byte_sop, byte_eop, byte_valid, overflow, frame_err
    );
`endif
endinterface

// File: rtl/router_port_rx.sv
// -----------------------------------------------------------------------------
// router_port_rx
// Purpose : Receive side of one router output port. Deserialises the LSB-first
//           serial payload into bytes, tags start/end of packet and buffers
//           {data, sop, eop} in a FIFO presented as a valid/ready byte stream.
// Ports   :
//   clock     in  single rising-edge clock
//   reset_n   in  asynchronous active-low reset
//   rx        slave modport of router_port_rx_if (serial in, byte stream out,
//             sticky overflow / frame_err flags)
// Config  : define RX_STATS_EN to add the 16-bit wrapping pkt_cnt / drop_cnt
//           counters; without it the counters do not exist.
// -----------------------------------------------------------------------------
module router_port_rx #(
    parameter int unsigned FIFO_DEPTH = 16,
    localparam int unsigned AW = $clog2(FIFO_DEPTH)
) (
    input logic            clock,
    input logic            reset_n,
    router_port_rx_if.slave rx
);

    typedef enum logic {StIdle, StRecv} state_e;

    state_e      r_state;
    state_e      w_state_nxt;
    logic        r_armed;
    logic [2:0]  r_bit_cnt;
    logic [6:0]  r_shift;
    logic        r_sop_pend;
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    logic [9:0]  r_mem [FIFO_DEPTH];
    logic        r_overflow;
    logic        r_frame_err;

    logic        w_accept;
    logic        w_complete;
    logic        w_pkt_end;
    logic        w_enter;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push;
    logic        w_drop;
    logic [9:0]  w_entry;

    // After reset the receiver stays deaf until frameo_n has been seen high, so a
    // packet already in flight at reset release is not picked up half way.
    assign w_accept   = !rx.valido_n && ((r_state == StRecv) || (!rx.frameo_n && r_armed));
    assign w_complete = w_accept && (r_bit_cnt == 3'd7);
    assign w_pkt_end  = (r_state == StRecv) && rx.frameo_n;
    assign w_enter    = (r_state == StIdle) && (w_state_nxt == StRecv);

    // Entry layout: {data[7:0], sop, eop}; eop is frameo_n of the completing cycle.
    assign w_entry = {rx.dout, r_shift, r_sop_pend, rx.frameo_n};

    // FIFO status; pointers carry one extra wrap bit.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop   = !w_empty && rx.byte_ready;
    assign w_push  = w_complete && (!w_full || w_pop);
    assign w_drop  = w_complete && w_full && !w_pop;

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StIdle: if (!rx.frameo_n && r_armed) w_state_nxt = StRecv;
            StRecv: if (rx.frameo_n)             w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Deserialiser and framing state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_armed     <= 1'b0;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_sop_pend  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (rx.frameo_n) begin
                r_armed <= 1'b1;
            end

            if (w_accept && (r_bit_cnt != 3'd7)) begin
                r_shift[r_bit_cnt] <= rx.dout;
            end

            if (w_pkt_end) begin
                r_bit_cnt <= 3'd0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            // sop belongs to the first completed byte of the packet, kept or dropped.
            if (w_enter) begin
                r_sop_pend <= 1'b1;
            end else if (w_complete || (w_state_nxt == StIdle)) begin
                r_sop_pend <= 1'b0;
            end

            // Packet ended without completing a byte in its final cycle.
            if (w_pkt_end && !w_complete) begin
                r_frame_err <= 1'b1;
            end
        end
    end

    // FIFO pointers and overflow flag
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // FIFO storage; contents are only observed through the empty-gated head.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= w_entry;
        end
    end

    // Head outputs read out at the read pointer, forced to zero while empty.
    always_comb begin
        rx.byte_data  = 8'd0;
        rx.byte_sop   = 1'b0;
        rx.byte_eop   = 1'b0;
        rx.byte_valid = !w_empty;
        if (!w_empty) begin
            rx.byte_data = r_mem[r_rd_ptr[AW-1:0]][9:2];
            rx.byte_sop  = r_mem[r_rd_ptr[AW-1:0]][1];
            rx.byte_eop  = r_mem[r_rd_ptr[AW-1:0]][0];
        end
    end

    assign rx.overflow  = r_overflow;
    assign rx.frame_err = r_frame_err;

`ifdef RX_STATS_EN
    logic [15:0] r_pkt_cnt;
    logic [15:0] r_drop_cnt;

    // Free-running wrapping counters.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_pkt_cnt  <= 16'd0;
            r_drop_cnt <= 16'd0;
        end else begin
            if (w_push && rx.frameo_n) begin
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign rx.pkt_cnt  = r_pkt_cnt;
    assign rx.drop_cnt = r_drop_cnt;
`endif

endmodule
